// File: rtl/jtdsp16_ram_ctrl.sv
// jtdsp16_ram_ctrl: JTDSP16 data RAM with a one-entry write buffer and read bypass.
// Define JTDSP16_RAM_CLEAR_EN to zero the whole array after reset (busy high meanwhile).
module jtdsp16_ram_ctrl #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] ram_addr,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

`ifdef JTDSP16_RAM_CLEAR_EN
    logic [DW-1:0] mem [0:DEPTH-1];
`else
    // Simulation starts from a zeroed array; hardware contents are undefined.
    logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};
`endif

    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_vld;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

`ifdef JTDSP16_RAM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && (&clr_cnt)) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (cen) begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // The buffer is never loaded while clearing, so the two write sources never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr;
        mem_wdata = wb_data;
        if (!rst) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
            end else if (wb_vld) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cen && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Bypass compares against the buffer as it stood before this edge, so a
    // store presented in the same cycle is not forwarded.
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            ram_dout <= '0;
            wb_vld   <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (cen && !busy) begin
            if (rd_en) ram_dout <= (wb_vld && wb_addr == ram_addr) ? wb_data : mem[ram_addr];
            if (wr_en) begin
                wb_vld  <= 1'b1;
                wb_addr <= ram_addr;
                wb_data <= wr_data;
            end else begin
                wb_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16_ram_ctrl.sv
// tb_jtdsp16_ram_ctrl: random and directed stimulus against a flat "latest value per address" model.
// Honours JTDSP16_RAM_CLEAR_EN the same way as the design.
module tb_jtdsp16_ram_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
`ifdef JTDSP16_RAM_CLEAR_EN
    localparam int CLR_LEN = DEPTH;
`else
    localparam int CLR_LEN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic [AW-1:0] ram_addr = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] ram_dout;
    logic          busy;

    jtdsp16_ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ram_addr (ram_addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    // clock
    always #5 clk = ~clk;

    // reference model: value each address holds as seen by the core
    logic [DW-1:0] mem_m [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_dout = '0;
    int            clear_left = 0;
    logic          undo_vld = 1'b0;
    logic [AW-1:0] undo_addr = '0;
    logic [DW-1:0] undo_val = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic cycle(input logic c, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        cen = c; rd_en = rd; wr_en = wr; ram_addr = a; wr_data = d;
        @(negedge clk);
        if (c) begin
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                if (rd) exp_q.push_back(mem_m[a]);
                if (wr) begin
                    undo_vld  = 1'b1;
                    undo_addr = a;
                    undo_val  = mem_m[a];
                    mem_m[a]  = d;
                end else begin
                    undo_vld = 1'b0;
                end
            end
        end
        if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
        check("dout", 32'(ram_dout), 32'(exp_dout));
        check("busy", 32'(busy), 32'(clear_left > 0));
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // the store still waiting in the buffer is lost
        if (undo_vld) mem_m[undo_addr] = undo_val;
        undo_vld = 1'b0;
        exp_q.delete();
        exp_dout = '0;
        if (CLR_LEN > 0) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end
        clear_left = CLR_LEN;
        check("rst_dout", 32'(ram_dout), 32'h0);
        check("rst_busy", 32'(busy), 32'(CLR_LEN > 0));
        rst = 1'b0;
    endtask

    task automatic rand_cycle(input int amax);
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, amax)), DW'($urandom));
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (busy && cnt < 4000) begin
            cnt++;
            rand_cycle(DEPTH - 1);
        end
        check("clear_len", 32'(cnt), 32'(CLR_LEN));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // power-on clear, then a mid-clear reset at clr_cnt = 0x100
        do_reset();
        for (int i = 0; i < 256; i++) rand_cycle(DEPTH - 1);
        do_reset();
        wait_clear();
        cycle(1'b1, 1'b1, 1'b0, 11'h7FF, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("clear_7ff", 32'(ram_dout), 32'h0);

        // bypass read, then array read
        cycle(1'b1, 1'b0, 1'b1, 11'h005, 16'h1234);
        cycle(1'b1, 1'b1, 1'b0, 11'h005, '0);
        check("bypass", 32'(ram_dout), 32'h1234);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 11'h005, '0);
        check("array_rd", 32'(ram_dout), 32'h1234);

        // back-to-back stores
        cycle(1'b1, 1'b0, 1'b1, 11'h010, 16'hAAAA);
        cycle(1'b1, 1'b0, 1'b1, 11'h011, 16'h5555);
        cycle(1'b1, 1'b1, 1'b0, 11'h010, '0);
        check("b2b_010", 32'(ram_dout), 32'hAAAA);
        cycle(1'b1, 1'b1, 1'b0, 11'h011, '0);
        check("b2b_011", 32'(ram_dout), 32'h5555);

        // same-cycle read and write return the old value
        cycle(1'b1, 1'b0, 1'b1, 11'h042, 16'h0001);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b1, 11'h042, 16'h0002);
        check("same_old", 32'(ram_dout), 32'h0001);
        cycle(1'b1, 1'b1, 1'b0, 11'h042, '0);
        check("same_new", 32'(ram_dout), 32'h0002);

        // clock-enable gating with a store pending
        cycle(1'b1, 1'b0, 1'b1, 11'h043, 16'h7777);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 11'h043, DW'($urandom));
        check("gate_hold", 32'(ram_dout), 32'h0002);
        cycle(1'b1, 1'b1, 1'b0, 11'h043, '0);
        check("gate_043", 32'(ram_dout), 32'h7777);

        // randomized traffic, mostly on a few addresses to exercise bypass
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), DW'($urandom));
            else
                rand_cycle(($urandom_range(0, 7) == 0) ? DEPTH - 1 : 7);
        end

        // reset with a store pending discards it
        cycle(1'b1, 1'b0, 1'b1, 11'h020, 16'h1111);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b1, 11'h020, 16'hBEEF);
        do_reset();
        wait_clear();
        cycle(1'b1, 1'b1, 1'b0, 11'h020, '0);
        check("discard", 32'(ram_dout == 16'hBEEF), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 11'h020, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
